// File: rtl/decryption_top.sv
// decryption_top: iterative AES-128 decryptor, one inverse round per clock.
// Optional KEY_CACHE_EN macro reuses round key 10 when the cipher key repeats.
module decryption_top #(
    parameter bit DONE_STICKY = 1'b0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [127:0] ciphertext,
    input  logic [127:0] key,
    output logic [127:0] plaintext,
    output logic         done,
    output logic         busy
);
    typedef enum logic [2:0] {IDLE, KEYGEN, INIT, ROUND, FINAL} state_t;

    state_t state, state_nx;
    logic [127:0] ct_reg, key_reg, st, sub, key_fwd, key_inv, cached_rk10;
    logic [31:0] sw_in, sw_out, fw0, iw0, rc_word;
    logic [3:0] rnd;
    logic accept, hit;

    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x;
        p = '0;
        x = a;
        for (int i = 0; i < 8; i++) begin
            p = b[i] ? p ^ x : p;
            x = xt(x);
        end
        return p;
    endfunction

    // Multiplicative inverse in GF(2^8) as x^254; maps 0 to 0.
    function automatic logic [7:0] ginv(input logic [7:0] x);
        logic [7:0] x2, x3, x12, x15, x240;
        x2   = gmul(x, x);
        x3   = gmul(x2, x);
        x12  = gmul(gmul(x3, x3), gmul(x3, x3));
        x15  = gmul(x12, x3);
        x240 = gmul(gmul(x15, x15), gmul(x15, x15));
        x240 = gmul(gmul(x240, x240), gmul(x240, x240));
        return gmul(gmul(x240, x12), x2);
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] y;
        y = ginv(x);
        return y ^ {y[6:0], y[7]} ^ {y[5:0], y[7:6]} ^ {y[4:0], y[7:5]} ^ {y[3:0], y[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] s);
        return ginv({s[6:0], s[7]} ^ {s[4:0], s[7:5]} ^ {s[1:0], s[7:2]} ^ 8'h05);
    endfunction

    // InvSubBytes(InvShiftRows(s)); byte r+4c sits at bits [127-8(r+4c) -: 8].
    function automatic logic [127:0] inv_sub_shift(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                o[127 - 8*(r + 4*c) -: 8] = inv_sbox(s[127 - 8*(r + 4*((c - r + 4) % 4)) -: 8]);
        return o;
    endfunction

    function automatic logic [127:0] inv_mix(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0] a0, a1, a2, a3;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127 - 32*c -: 8];
            a1 = s[119 - 32*c -: 8];
            a2 = s[111 - 32*c -: 8];
            a3 = s[103 - 32*c -: 8];
            o[127 - 32*c -: 8] = gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09);
            o[119 - 32*c -: 8] = gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d);
            o[111 - 32*c -: 8] = gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b);
            o[103 - 32*c -: 8] = gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e);
        end
        return o;
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] i);
        return (i == 4'd9) ? 8'h1b : (i == 4'd10) ? 8'h36 : 8'h01 << (i - 4'd1);
    endfunction

    assign accept = (state == IDLE) && start;
    assign busy   = (state != IDLE);
    assign sub    = inv_sub_shift(st);

    // The four S-boxes are shared: forward expansion feeds w3, inverse feeds the recovered w3.
    assign sw_in   = (state == KEYGEN) ? key_reg[31:0] : key_reg[31:0] ^ key_reg[63:32];
    assign sw_out  = {sbox(sw_in[23:16]), sbox(sw_in[15:8]), sbox(sw_in[7:0]), sbox(sw_in[31:24])};
    assign rc_word = {rcon(rnd), 24'h0};
    assign fw0     = key_reg[127:96] ^ sw_out ^ rc_word;
    assign iw0     = key_reg[127:96] ^ sw_out ^ rc_word;
    assign key_fwd = {fw0, fw0 ^ key_reg[95:64], fw0 ^ key_reg[95:64] ^ key_reg[63:32],
                      fw0 ^ key_reg[95:64] ^ key_reg[63:32] ^ key_reg[31:0]};
    assign key_inv = {iw0, key_reg[95:64] ^ key_reg[127:96], key_reg[63:32] ^ key_reg[95:64],
                      key_reg[31:0] ^ key_reg[63:32]};

`ifdef KEY_CACHE_EN
    logic [127:0] last_key, last_rk10;
    logic cache_valid;
    assign hit         = cache_valid && (key == last_key);
    assign cached_rk10 = last_rk10;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_key    <= '0;
            last_rk10   <= '0;
            cache_valid <= 1'b0;
        end else if (accept && !hit) begin
            last_key    <= key;
            cache_valid <= 1'b0;
        end else if (state == KEYGEN && rnd == 4'd10) begin
            last_rk10   <= key_fwd;
            cache_valid <= 1'b1;
        end
    end
`else
    assign hit         = 1'b0;
    assign cached_rk10 = '0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = start ? (hit ? INIT : KEYGEN) : IDLE;
            KEYGEN:  state_nx = (rnd == 4'd10) ? INIT : KEYGEN;
            INIT:    state_nx = ROUND;
            ROUND:   state_nx = (rnd == 4'd1) ? FINAL : ROUND;
            FINAL:   state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ct_reg    <= '0;
            key_reg   <= '0;
            st        <= '0;
            rnd       <= '0;
            plaintext <= '0;
            done      <= 1'b0;
        end else begin
            done <= (state == FINAL) || (DONE_STICKY && done && !accept);
            case (state)
                IDLE: if (start) begin
                    ct_reg  <= ciphertext;
                    key_reg <= hit ? cached_rk10 : key;
                    rnd     <= hit ? 4'd10 : 4'd1;
                end
                KEYGEN: begin
                    key_reg <= key_fwd;
                    rnd     <= (rnd == 4'd10) ? rnd : rnd + 4'd1;
                end
                INIT: begin
                    st      <= ct_reg ^ key_reg;
                    key_reg <= key_inv;
                    rnd     <= 4'd9;
                end
                ROUND: begin
                    st      <= inv_mix(sub ^ key_reg);
                    key_reg <= key_inv;
                    rnd     <= rnd - 4'd1;
                end
                FINAL: plaintext <= sub ^ key_reg;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_decryption_top.sv
// tb_decryption_top: directed FIPS-197 vectors against decryption_top.
module tb_decryption_top;
    localparam logic [127:0] K1 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] P1 = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] K2 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] C2 = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] P2 = 128'h3243f6a8885a308d313198a2e0370734;
`ifdef KEY_CACHE_EN
    localparam int HIT_LAT = 11;
`else
    localparam int HIT_LAT = 21;
`endif

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic start = 1'b0;
    logic [127:0] ciphertext = '0;
    logic [127:0] key = '0;
    logic [127:0] plaintext;
    logic done, busy;
    int n_checks = 0;
    int n_fail = 0;

    decryption_top dut (
        .clk(clk), .reset(reset), .start(start), .ciphertext(ciphertext), .key(key),
        .plaintext(plaintext), .done(done), .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    // Accepts one block and waits (bounded) for done; inputs are scrambled after accept.
    task automatic run_op(input logic [127:0] c, input logic [127:0] k, output int lat, output logic [127:0] pt);
        @(negedge clk);
        ciphertext = c; key = k; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; ciphertext = ~c; key = ~k;
        lat = 0;
        while (!done && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        pt = plaintext;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_checks++; if (plaintext !== '0) begin n_fail++; $display("FAIL reset_pt got %h want 0", plaintext); end
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", done); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_fips_c1;
        int lat;
        @(negedge clk);
        ciphertext = C1; key = K1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; ciphertext = '0; key = '0;
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL c1_busy_accept got %b want 1", busy); end
        lat = 0;
        while (!done && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        n_checks++; if (lat !== 21) begin n_fail++; $display("FAIL c1_latency got %0d want 21", lat); end
        n_checks++; if (plaintext !== P1) begin n_fail++; $display("FAIL c1_pt got %h want %h", plaintext, P1); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL c1_busy_done got %b want 0", busy); end
        @(posedge clk); #1;
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL c1_done_pulse got %b want 0", done); end
        repeat (3) @(posedge clk);
        #1;
        n_checks++; if (plaintext !== P1) begin n_fail++; $display("FAIL c1_pt_hold got %h want %h", plaintext, P1); end
    endtask

    task automatic test_fips_b;
        int lat;
        logic [127:0] pt;
        run_op(C2, K2, lat, pt);
        n_checks++; if (lat !== 21) begin n_fail++; $display("FAIL b_latency got %0d want 21", lat); end
        n_checks++; if (pt !== P2) begin n_fail++; $display("FAIL b_pt got %h want %h", pt, P2); end
    endtask

    task automatic test_ignore_start;
        int ndone, dcyc, bad_busy;
        ndone = 0; dcyc = 0; bad_busy = 0;
        @(negedge clk);
        ciphertext = C1; key = K1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int cyc = 1; cyc <= 30; cyc++) begin
            start = (cyc == 5 || cyc == 12);
            if (start) begin ciphertext = C2; key = K2; end
            @(posedge clk); #1;
            if (done) begin ndone++; dcyc = cyc; end
            if (cyc < 21 && !busy) bad_busy++;
        end
        start = 1'b0;
        n_checks++; if (ndone !== 1) begin n_fail++; $display("FAIL ign_done_count got %0d want 1", ndone); end
        n_checks++; if (dcyc !== 21) begin n_fail++; $display("FAIL ign_done_cycle got %0d want 21", dcyc); end
        n_checks++; if (bad_busy !== 0) begin n_fail++; $display("FAIL ign_busy_drops got %0d want 0", bad_busy); end
        n_checks++; if (plaintext !== P1) begin n_fail++; $display("FAIL ign_pt got %h want %h", plaintext, P1); end
    endtask

    task automatic test_reset_mid;
        int lat;
        logic [127:0] pt;
        @(negedge clk);
        ciphertext = C2; key = K2; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (8) @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        n_checks++; if (plaintext !== '0) begin n_fail++; $display("FAIL mid_reset_pt got %h want 0", plaintext); end
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL mid_reset_done got %b want 0", done); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL mid_reset_busy got %b want 0", busy); end
        @(negedge clk);
        reset = 1'b0;
        run_op(C1, K1, lat, pt);
        n_checks++; if (lat !== 21) begin n_fail++; $display("FAIL mid_after_latency got %0d want 21", lat); end
        n_checks++; if (pt !== P1) begin n_fail++; $display("FAIL mid_after_pt got %h want %h", pt, P1); end
    endtask

    task automatic test_back_to_back;
        int cyc, d1, d2;
        logic [127:0] p1, p2;
        cyc = 0; d1 = 0; d2 = 0; p1 = '0; p2 = '0;
        @(negedge clk);
        ciphertext = C2; key = K2; start = 1'b1;
        @(posedge clk); #1;
        ciphertext = C1; key = K1;
        while (cyc < 60 && d2 == 0) begin
            @(posedge clk); #1;
            cyc++;
            if (d1 != 0 && cyc == d1 + 1) begin
                start = 1'b0;
                n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL b2b_done_drop got %b want 0", done); end
            end else if (done) begin
                if (d1 == 0) begin d1 = cyc; p1 = plaintext; end
                else begin d2 = cyc; p2 = plaintext; end
            end
        end
        start = 1'b0;
        n_checks++; if (d1 !== 21) begin n_fail++; $display("FAIL b2b_first_cycle got %0d want 21", d1); end
        n_checks++; if (p1 !== P2) begin n_fail++; $display("FAIL b2b_first_pt got %h want %h", p1, P2); end
        n_checks++; if (d2 - d1 !== 22) begin n_fail++; $display("FAIL b2b_spacing got %0d want 22", d2 - d1); end
        n_checks++; if (p2 !== P1) begin n_fail++; $display("FAIL b2b_second_pt got %h want %h", p2, P1); end
    endtask

    task automatic test_key_reuse;
        int lat;
        logic [127:0] pt;
        run_op(C1, K1, lat, pt);
        n_checks++; if (lat !== HIT_LAT) begin n_fail++; $display("FAIL reuse_latency got %0d want %0d", lat, HIT_LAT); end
        n_checks++; if (pt !== P1) begin n_fail++; $display("FAIL reuse_pt got %h want %h", pt, P1); end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        run_op(C1, K1, lat, pt);
        n_checks++; if (lat !== 21) begin n_fail++; $display("FAIL reuse_after_reset_latency got %0d want 21", lat); end
        n_checks++; if (pt !== P1) begin n_fail++; $display("FAIL reuse_after_reset_pt got %h want %h", pt, P1); end
    endtask

    initial begin
        test_reset();
        test_fips_c1();
        test_fips_b();
        test_ignore_start();
        test_reset_mid();
        test_back_to_back();
        test_key_reuse();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
